gray_pixel_packer: RTL and testbench
====================================

GRAY_PIXEL_PACKER -- requirements
Module: gray_pixel_packer

Interface
REQ-001 The module SHALL have parameter IMG_W, default 640, pixels per line, a multiple of 4.
REQ-002 The module SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 The module SHALL have parameter ADDR_W, default 17, word-address width.
REQ-004 The module SHALL have parameter FIFO_DEPTH, default 4, output word FIFO entries, a power of 2.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port start_i, input, 1: one-cycle pulse that arms capture of one frame.
REQ-008 Port gray_i, input, 8: grayscale pixel from the rgb2gray stage.
REQ-009 Port gray_valid_i, input, 1: pixel strobe (the upstream done_o); gray_i is valid when it is high.
REQ-010 Port word_o, output, 32: packed word of 4 pixels; the first pixel is in [7:0] and the fourth in [31:24].
REQ-011 Port addr_o, output, ADDR_W: word address of word_o, 0 at frame start.
REQ-012 Port word_valid_o, output, 1: word_o and addr_o are valid.
REQ-013 Port word_ready_i, input, 1: sink accepts the word; a transfer occurs when valid and ready are both high.
REQ-014 Port busy_o, output, 1: high in RUN or DRAIN.
REQ-015 Port frame_done_o, output, 1: one-cycle pulse when the last word of the frame transfers.
REQ-016 Port overflow_o, output, 1: sticky flag set when a word is dropped because the FIFO is full.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-018 IDLE SHALL go to RUN on start_i; pixel, column, row and address counters SHALL clear, and overflow_o SHALL clear.
REQ-019 In IDLE and DRAIN, gray_valid_i SHALL be ignored.
REQ-020 In RUN, each gray_valid_i SHALL shift gray_i into byte lane pix_cnt and increment pix_cnt modulo 4.
REQ-021 On the 4th pixel, the assembled word and the current address SHALL be pushed into the FIFO on the same edge, and the address SHALL increment.
REQ-022 A pushed word SHALL appear on word_valid_o one cycle after the 4th pixel strobe if the FIFO was empty.
REQ-023 The column counter SHALL wrap at IMG_W-1 and increment the row counter.
REQ-024 RUN SHALL go to DRAIN on the strobe of pixel (IMG_W-1, IMG_H-1).
REQ-025 DRAIN SHALL go to IDLE when the FIFO empties; frame_done_o SHALL pulse on the cycle of the final transfer.
REQ-026 A push into a full FIFO SHALL succeed if a pop occurs on the same cycle.
REQ-027 A push into a full FIFO with no pop SHALL drop the word, set overflow_o, and still increment the address.
REQ-028 Simultaneous push and pop on an empty FIFO SHALL NOT bypass; the word SHALL be output on the next cycle.
REQ-029 start_i SHALL be ignored outside IDLE.
REQ-030 word_o and addr_o SHALL hold stable while word_valid_o is high and word_ready_i is low.

Reset
REQ-031 On rst, the FSM SHALL enter IDLE and the FIFO SHALL empty.
REQ-032 On rst, all counters SHALL be 0.
REQ-033 On rst, word_o, addr_o, word_valid_o, busy_o, frame_done_o and overflow_o SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no frame_done_o pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the word width (32) and the pixel width (8).
REQ-036 The FIFO SHALL be a separate sub-module, word_fifo, a synchronous FIFO with registered outputs.

Verification
REQ-037 With IMG_W=8, IMG_H=2 and word_ready_i=1, start_i followed by 16 strobes of gray 0x00..0x0F SHALL produce words 0x03020100@0, 0x07060504@1, 0x0B0A0908@2 and 0x0F0E0D0C@3, with frame_done_o on the 4th transfer and busy_o then low.
REQ-038 Strobes with gaps (gray_valid_i low 3 cycles between pixels) SHALL produce identical words and addresses.
REQ-039 With word_ready_i=0 for the whole frame and FIFO_DEPTH=2, 2 words SHALL be held, and the 3rd and 4th SHALL be dropped with overflow_o=1. When ready then rises, 0x03020100@0 and 0x07060504@1 SHALL transfer and frame_done_o SHALL pulse.
REQ-040 Strobes before start_i, and a start_i pulse during RUN, SHALL produce no words and leave the counters unchanged.
REQ-041 rst asserted after 6 pixels SHALL immediately zero all outputs; a new start_i and 16 pixels SHALL restart at address 0.
REQ-042 Holding word_ready_i low for 5 cycles with word_valid_o high SHALL keep word_o and addr_o constant, and a single transfer SHALL occur when ready rises.

Source files
------------

// File: rtl/gray_pixel_packer_pkg.sv
// Shared types and constants for the grayscale pixel packer.
package gray_pixel_packer_pkg;

    localparam int WORD_W = 32;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Returns word with byte lane 'lane' replaced by 'pix'.
    function automatic logic [WORD_W-1:0] insertLane(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        lane,
        input logic [PIX_W-1:0]  pix
    );
        logic [WORD_W-1:0] result;
        result = word;
        result[lane*PIX_W +: PIX_W] = pix;
        return result;
    endfunction

endpackage

// File: rtl/gray_pixel_packer_word_fifo.sv
// Synchronous FIFO whose head entry and valid flag are registered.
// A word pushed into an empty FIFO shows up on the cycle after the push,
// so there is no same-cycle bypass path from i_data to o_data.
module word_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 49
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_lastOne
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    logic              w_doPop;
    logic              w_doPush;
    logic [PTR_W-1:0]  w_rdPtrNext;
    logic [PTR_W-1:0]  w_wrPtrNext;
    logic [CNT_W-1:0]  w_remain;
    logic [CNT_W-1:0]  w_countNext;
    logic [DATA_W-1:0] w_headNext;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign w_doPop  = i_pop && (r_count != '0);
    assign w_doPush = i_push && ((r_count != FULL_CNT) || w_doPop);

    // Next pointers, occupancy and the entry that becomes the head after this edge.
    always_comb begin
        w_rdPtrNext = r_rdPtr;
        w_wrPtrNext = r_wrPtr;
        if (w_doPop) begin
            w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
        end
        if (w_doPush) begin
            w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
        end
        w_remain    = r_count - CNT_W'(w_doPop);
        w_countNext = w_remain + CNT_W'(w_doPush);
        w_headNext  = (w_remain == '0) ? i_data : r_mem[w_rdPtrNext];
    end

    // Storage array; written only, never reset, since occupancy tracks validity.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers, occupancy and the registered head/valid outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_wrPtr <= w_wrPtrNext;
            r_rdPtr <= w_rdPtrNext;
            r_count <= w_countNext;
            r_valid <= (w_countNext != '0);
            if (w_countNext != '0) begin
                r_data <= w_headNext;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_full    = (r_count == FULL_CNT);
    assign o_lastOne = (r_count == ONE_CNT);

endmodule

// File: rtl/gray_pixel_packer.sv
// Packs a frame of 8-bit grayscale pixels into 32-bit words with word
// addresses and hands them to a sink through a small output FIFO.
module gray_pixel_packer
    import gray_pixel_packer_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [PIX_W-1:0]  gray_i,
    input  logic              gray_valid_i,
    output logic [WORD_W-1:0] word_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              overflow_o
);

    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FIFO_W = WORD_W + ADDR_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_pixCnt;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_word;
    logic              r_overflow;

    logic              w_startFrame;
    logic              w_strobe;
    logic              w_fourth;
    logic              w_lastPixel;
    logic              w_drop;
    logic              w_lastXfer;
    logic [WORD_W-1:0] w_fullWord;
    logic [FIFO_W-1:0] w_fifoIn;
    logic [FIFO_W-1:0] w_fifoOut;
    logic              w_fifoFull;
    logic              w_fifoLast;

    // Pixel strobes only count while a frame is being captured.
    assign w_startFrame = (r_state == IDLE) && start_i;
    assign w_strobe     = (r_state == RUN) && gray_valid_i;
    assign w_fourth     = w_strobe && (r_pixCnt == 2'd3);
    assign w_lastPixel  = w_strobe && (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign w_fullWord   = insertLane(r_word, r_pixCnt, gray_i);
    assign w_fifoIn     = {r_addr, w_fullWord};
    assign w_drop       = w_fourth && w_fifoFull && !word_ready_i;
    assign w_lastXfer   = word_valid_o && word_ready_i && w_fifoLast;

    word_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_fourth),
        .i_data    (w_fifoIn),
        .i_pop     (word_ready_i),
        .o_data    (w_fifoOut),
        .o_valid   (word_valid_o),
        .o_full    (w_fifoFull),
        .o_lastOne (w_fifoLast)
    );

    assign word_o     = w_fifoOut[WORD_W-1:0];
    assign addr_o     = w_fifoOut[FIFO_W-1:WORD_W];
    assign overflow_o = r_overflow;

    // State register for the capture sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus busy and end-of-frame indications.
    always_comb begin
        w_nextState  = r_state;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (w_lastPixel) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (w_lastXfer) begin
                    frame_done_o = 1'b1;
                    w_nextState  = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Byte-lane assembly plus pixel, column, row and word-address counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixCnt <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_addr   <= '0;
            r_word   <= '0;
        end else if (w_startFrame) begin
            r_pixCnt <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_addr   <= '0;
            r_word   <= '0;
        end else if (w_strobe) begin
            r_word   <= w_fullWord;
            r_pixCnt <= r_pixCnt + 2'd1;
            if (w_fourth) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Sticky flag recording that a completed word found no room in the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_startFrame) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_pixel_packer.sv
// Testbench for gray_pixel_packer: a queue-based frame model is compared
// against the DUT every cycle, with literal expectations for known frames.
module tb_gray_pixel_packer;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef struct packed {
        logic [31:0]       word;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [7:0]        gray_i;
    logic              gray_valid_i;
    logic [31:0]       word_o;
    logic [ADDR_W-1:0] addr_o;
    logic              word_valid_o;
    logic              word_ready_i;
    logic              busy_o;
    logic              frame_done_o;
    logic              overflow_o;

    int checks = 0;
    int errors = 0;
    bit randReady = 1'b0;

    entry_t      mQ[$];
    bit          mRun;
    bit          mDrain;
    bit          mOvf;
    int          mPix;
    logic [7:0]  mBuf[4];
    logic [ADDR_W-1:0] mAddr;

    logic [31:0]       logWord[$];
    logic [ADDR_W-1:0] logAddr[$];
    int                doneCount = 0;
    logic [7:0]        pix[NPIX];

    always #5 clk = ~clk;

    gray_pixel_packer #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .gray_i       (gray_i),
        .gray_valid_i (gray_valid_i),
        .word_o       (word_o),
        .addr_o       (addr_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o)
    );

    // Records one comparison and reports it when the values differ.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Frame model: a word is four consecutive pixels, kept in a bounded queue.
    always @(posedge clk or posedge rst) begin : modelProc
        entry_t e;
        bit popNow;
        bit hadOne;
        bit pushNow;
        if (rst) begin
            mQ.delete();
            mRun   = 1'b0;
            mDrain = 1'b0;
            mOvf   = 1'b0;
            mPix   = 0;
            mAddr  = '0;
        end else begin
            pushNow = 1'b0;
            e       = '0;
            popNow  = (mQ.size() > 0) && word_ready_i;
            hadOne  = (mQ.size() == 1);
            if (!mRun && !mDrain) begin
                if (start_i) begin
                    mRun  = 1'b1;
                    mPix  = 0;
                    mAddr = '0;
                    mOvf  = 1'b0;
                end
            end else if (mRun) begin
                if (gray_valid_i) begin
                    mBuf[mPix % 4] = gray_i;
                    mPix++;
                    if (mPix % 4 == 0) begin
                        e.word = {mBuf[3], mBuf[2], mBuf[1], mBuf[0]};
                        e.addr = mAddr;
                        mAddr++;
                        if (mQ.size() < DEPTH || popNow) pushNow = 1'b1;
                        else mOvf = 1'b1;
                    end
                    if (mPix == NPIX) begin
                        mRun   = 1'b0;
                        mDrain = 1'b1;
                    end
                end
            end else begin
                if (popNow && hadOne) mDrain = 1'b0;
            end
            if (popNow) void'(mQ.pop_front());
            if (pushNow) mQ.push_back(e);
        end
    end

    // Every cycle, compare DUT outputs against the model.
    always @(negedge clk) begin
        checkOutput("word_valid_o", word_valid_o, mQ.size() > 0);
        if (mQ.size() > 0) begin
            checkOutput("word_o", word_o, mQ[0].word);
            checkOutput("addr_o", addr_o, mQ[0].addr);
        end
        checkOutput("busy_o", busy_o, mRun || mDrain);
        checkOutput("overflow_o", overflow_o, mOvf);
        checkOutput("frame_done_o", frame_done_o, mDrain && (mQ.size() == 1) && word_ready_i);
    end

    // Log transfers and end-of-frame pulses seen at the DUT boundary.
    always @(negedge clk) begin
        if (word_valid_o && word_ready_i) begin
            logWord.push_back(word_o);
            logAddr.push_back(addr_o);
        end
        if (frame_done_o) doneCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (randReady) word_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    // Drives one pixel strobe followed by 'gap' idle cycles.
    task automatic applyStimulus(input logic [7:0] g, input int gap);
        gray_valid_i = 1'b1;
        gray_i       = g;
        tick();
        gray_valid_i = 1'b0;
        gray_i       = $urandom_range(0, 255);
        repeat (gap) tick();
    endtask

    task automatic startFrame();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic clearLogs();
        logWord.delete();
        logAddr.delete();
        doneCount = 0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 400 && busy_o; i++) tick();
        checkOutput("drainTimeout", busy_o, 1'b0);
        tick();
    endtask

    task automatic checkLog(input int idx, input logic [31:0] w, input logic [ADDR_W-1:0] a);
        if (idx < logWord.size()) begin
            checkOutput("logWord", logWord[idx], w);
            checkOutput("logAddr", logAddr[idx], a);
        end else begin
            checkOutput("logMissing", 0, 1);
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, ".word_o"}, word_o, 0);
        checkOutput({tag, ".addr_o"}, addr_o, 0);
        checkOutput({tag, ".word_valid_o"}, word_valid_o, 0);
        checkOutput({tag, ".busy_o"}, busy_o, 0);
        checkOutput({tag, ".frame_done_o"}, frame_done_o, 0);
        checkOutput({tag, ".overflow_o"}, overflow_o, 0);
    endtask

    task automatic checkKnownFrame(input string tag);
        checkOutput({tag, ".count"}, logWord.size(), 4);
        checkLog(0, 32'h03020100, 0);
        checkLog(1, 32'h07060504, 1);
        checkLog(2, 32'h0B0A0908, 2);
        checkLog(3, 32'h0F0E0D0C, 3);
        checkOutput({tag, ".done"}, doneCount, 1);
        checkOutput({tag, ".busy"}, busy_o, 0);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        gray_i       = '0;
        gray_valid_i = 1'b0;
        word_ready_i = 1'b1;
        #3;
        checkZeroOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Strobes while idle produce nothing.
        clearLogs();
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA0 + i), 0);
        checkOutput("preStart.words", logWord.size(), 0);
        checkOutput("preStart.busy", busy_o, 0);

        // Back-to-back frame with ready held high.
        clearLogs();
        startFrame();
        for (int i = 0; i < NPIX; i++) applyStimulus(8'(i), 0);
        waitIdle();
        checkKnownFrame("frame1");

        // Gapped strobes with a stray start pulse mid-frame.
        clearLogs();
        startFrame();
        for (int i = 0; i < NPIX; i++) begin
            applyStimulus(8'(i), 3);
            if (i == 5) begin
                start_i = 1'b1;
                tick();
                start_i = 1'b0;
            end
        end
        waitIdle();
        checkKnownFrame("gapped");

        // Sink stalled for the whole frame: two held, two dropped.
        clearLogs();
        word_ready_i = 1'b0;
        startFrame();
        for (int i = 0; i < NPIX; i++) applyStimulus(8'(i), 0);
        repeat (3) tick();
        checkOutput("stall.overflow", overflow_o, 1);
        checkOutput("stall.valid", word_valid_o, 1);
        checkOutput("stall.word", word_o, 32'h03020100);
        checkOutput("stall.words", logWord.size(), 0);
        word_ready_i = 1'b1;
        waitIdle();
        checkOutput("stall.count", logWord.size(), 2);
        checkLog(0, 32'h03020100, 0);
        checkLog(1, 32'h07060504, 1);
        checkOutput("stall.done", doneCount, 1);

        // Reset after six pixels aborts the frame.
        clearLogs();
        startFrame();
        for (int i = 0; i < 6; i++) applyStimulus(8'(8'h50 + i), 0);
        rst = 1'b1;
        #1;
        checkZeroOutputs("midReset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checkOutput("midReset.done", doneCount, 0);

        // Fresh frame after the abort, random pixels and random ready.
        clearLogs();
        startFrame();
        randReady = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            pix[i] = 8'($urandom_range(0, 255));
            applyStimulus(pix[i], 0);
        end
        randReady = 1'b0;
        word_ready_i = 1'b1;
        waitIdle();
        if (!overflow_o) begin
            checkOutput("restart.count", logWord.size(), 4);
            for (int w = 0; w < 4; w++)
                checkLog(w, {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]}, ADDR_W'(w));
        end else begin
            checkOutput("restart.firstAddr", logAddr.size() > 0 ? logAddr[0] : 8'hFF, 0);
        end
        checkOutput("restart.done", doneCount, 1);

        // Word held stable while the sink stalls, then one transfer.
        clearLogs();
        word_ready_i = 1'b0;
        startFrame();
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h40 + i), 0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold.word", word_o, 32'h43424140);
            checkOutput("hold.addr", addr_o, 0);
            checkOutput("hold.valid", word_valid_o, 1);
            tick();
        end
        word_ready_i = 1'b1;
        tick();
        word_ready_i = 1'b0;
        checkOutput("hold.transfers", logWord.size(), 1);
        word_ready_i = 1'b1;
        for (int i = 4; i < NPIX; i++) applyStimulus(8'(8'h40 + i), 0);
        waitIdle();
        checkOutput("hold.count", logWord.size(), 4);

        // Random frames with gaps and a randomly stalling sink.
        for (int f = 0; f < 6; f++) begin
            clearLogs();
            randReady = 1'b1;
            startFrame();
            for (int i = 0; i < NPIX; i++) applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 2));
            waitIdle();
            randReady = 1'b0;
            word_ready_i = 1'b1;
            checkOutput("random.done", doneCount, 1);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
